sram_controller: RTL and testbench

Responder for the pipeline's data-memory interface. The MEM stage issues 32-bit word reads and writes. This block serves each request as two 16-bit accesses to an external asynchronous SRAM and holds `ready` low until the word is complete; the pipeline freezes while `ready` is low. It sits between the MEM stage and the board SRAM pins, and it is the only block that owns those pins.

---
 rtl/sram_pkg.sv | 14 +
 rtl/sram_phase_counter.sv | 26 ++
 rtl/sram_controller.sv | 157 +++++++++++++++
 tb/tb_sram_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the 32-bit-word to 16-bit-SRAM controller.
package sram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } sram_state_t;

   localparam int SRAM_DATA_BASE = 1024;
   localparam int SRAM_HALF_W    = 16;

endpackage

// File: rtl/sram_phase_counter.sv
// Down-counter timing one SRAM access phase; phase_last marks its final cycle.
module sram_phase_counter #(
   parameter int ACCESS_CYCLES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   output logic phase_last
);

   localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (load)
         cnt <= CNT_W'(ACCESS_CYCLES - 1);
      else if (cnt != '0)
         cnt <= cnt - CNT_W'(1);
   end

   assign phase_last = (cnt == '0);

endmodule

// File: rtl/sram_controller.sv
// Serves 32-bit MEM-stage reads/writes as two 16-bit async SRAM accesses,
// stalling the pipeline through ready until the word completes.
module sram_controller
   import sram_pkg::*;
#(
   parameter int ADDR_W        = 18,
   parameter int ACCESS_CYCLES = 2,
   parameter int DATA_BASE     = SRAM_DATA_BASE
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   mem_w_en,
   input  logic                   mem_r_en,
   input  logic [31:0]            address,
   input  logic [31:0]            st_value,
   output logic [31:0]            read_data,
   output logic                   ready,
   output logic [ADDR_W-1:0]      sram_addr,
   output logic [SRAM_HALF_W-1:0] sram_dq_out,
   output logic                   sram_dq_oe,
   input  logic [SRAM_HALF_W-1:0] sram_dq_in,
   output logic                   sram_we_n,
   output logic                   sram_oe_n
);

   sram_state_t state_q, state_d;

   logic                   req;
   logic                   load;
   logic                   phase_last;
   logic                   is_wr_q, is_wr_d;
   logic [ADDR_W-2:0]      word_q, word_d;
   logic [31:0]            st_q, st_d;
   logic [31:0]            offset;
   logic [SRAM_HALF_W-1:0] low_q;

   logic [ADDR_W-1:0]      addr_d;
   logic [SRAM_HALF_W-1:0] dq_out_d;
   logic                   dq_oe_d;
   logic                   we_n_d;
   logic                   oe_n_d;

   // Byte-lane bits and bits beyond the SRAM depth are dropped on purpose.
   logic unused_offset_bits;

   assign req    = mem_r_en | mem_w_en;
   assign offset = address - 32'(DATA_BASE);
   assign unused_offset_bits = ^{offset[31:ADDR_W+1], offset[1:0]};

   sram_phase_counter #(
      .ACCESS_CYCLES (ACCESS_CYCLES)
   ) u_phase (
      .clock      (clock),
      .reset      (reset),
      .load       (load),
      .phase_last (phase_last)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         is_wr_q <= 1'b0;
         word_q  <= '0;
         st_q    <= '0;
      end else begin
         state_q <= state_d;
         is_wr_q <= is_wr_d;
         word_q  <= word_d;
         st_q    <= st_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      ready   = 1'b0;
      is_wr_d = is_wr_q;
      word_d  = word_q;
      st_d    = st_q;
      case (state_q)
         IDLE: begin
            ready = !req;
            if (req) begin
               state_d = LOW;
               load    = 1'b1;
               is_wr_d = mem_w_en;   // write wins when both are raised
               word_d  = offset[ADDR_W:2];
               st_d    = st_value;
            end
         end
         LOW: begin
            if (phase_last) begin
               state_d = HIGH;
               load    = 1'b1;
            end
         end
         HIGH: begin
            if (phase_last)
               state_d = DONE;
         end
         DONE: begin
            ready   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pin values are derived from the next state so they register exactly at
   // phase boundaries and stay stable for the whole phase.
   always_comb begin
      addr_d   = sram_addr;
      dq_out_d = sram_dq_out;
      dq_oe_d  = 1'b0;
      we_n_d   = 1'b1;
      oe_n_d   = 1'b1;
      if (state_d == LOW || state_d == HIGH) begin
         addr_d = {word_d, (state_d == HIGH)};
         if (is_wr_d) begin
            dq_oe_d  = 1'b1;
            we_n_d   = 1'b0;
            dq_out_d = (state_d == HIGH) ? st_d[31:16] : st_d[15:0];
         end else begin
            oe_n_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
      end else begin
         sram_addr   <= addr_d;
         sram_dq_out <= dq_out_d;
         sram_dq_oe  <= dq_oe_d;
         sram_we_n   <= we_n_d;
         sram_oe_n   <= oe_n_d;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         low_q     <= '0;
         read_data <= '0;
      end else if (!is_wr_q && phase_last) begin
         if (state_q == LOW)
            low_q <= sram_dq_in;
         else if (state_q == HIGH)
            read_data <= {sram_dq_in, low_q};
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Directed + random bench for sram_controller against a word-level memory model.
module tb_sram_controller;

   localparam int N      = 2;
   localparam int ADDR_W = 18;
   localparam int DEPTH  = 1 << ADDR_W;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        mem_w_en = 1'b0;
   logic        mem_r_en = 1'b0;
   logic [31:0] address  = '0;
   logic [31:0] st_value = '0;
   logic [31:0] read_data;
   logic        ready;
   logic [ADDR_W-1:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;
   logic        sram_oe_n;

   int total = 0;
   int bad   = 0;

   logic [15:0] sram_mem [DEPTH];
   logic [31:0] ref_w [int];
   logic [31:0] exp_rdata = '0;

   always #5 clock = ~clock;

   sram_controller #(
      .ADDR_W        (ADDR_W),
      .ACCESS_CYCLES (N),
      .DATA_BASE     (1024)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .mem_w_en    (mem_w_en),
      .mem_r_en    (mem_r_en),
      .address     (address),
      .st_value    (st_value),
      .read_data   (read_data),
      .ready       (ready),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_oe  (sram_dq_oe),
      .sram_dq_in  (sram_dq_in),
      .sram_we_n   (sram_we_n),
      .sram_oe_n   (sram_oe_n)
   );

   // Behavioural asynchronous SRAM
   assign sram_dq_in = sram_oe_n ? 16'h0000 : sram_mem[sram_addr];
   always @(posedge clock)
      if (!sram_we_n && sram_dq_oe)
         sram_mem[sram_addr] <= sram_dq_out;

   function automatic logic [15:0] pat(input int h);
      return 16'(h * 40503) ^ 16'h5A5A;
   endfunction

   // Word index the spec's mapping gives a byte address (32-bit wrap, truncated).
   function automatic int word_idx(input logic [31:0] addr);
      return int'(((addr - 32'd1024) >> 2) & 32'(DEPTH / 2 - 1));
   endfunction

   function automatic logic [31:0] ref_rd(input int idx);
      if (ref_w.exists(idx))
         return ref_w[idx];
      return {pat(2 * idx + 1), pat(2 * idx)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
      check({tag, "_oe_n"}, 32'(sram_oe_n), 32'd1);
      check({tag, "_dq_oe"}, 32'(sram_dq_oe), 32'd0);
   endtask

   // One full transaction starting at the next negedge (cycle 0).
   task automatic txn(input logic wr, input logic rd, input logic [31:0] addr,
                      input logic [31:0] data);
      int idx;
      int c;
      logic is_wr;
      logic [31:0] exp_rd;
      logic [ADDR_W-1:0] a_lo;
      is_wr  = wr;
      idx    = word_idx(addr);
      a_lo   = ADDR_W'(idx * 2);
      exp_rd = is_wr ? exp_rdata : ref_rd(idx);
      @(negedge clock);
      mem_w_en = wr;
      mem_r_en = rd;
      address  = addr;
      st_value = data;
      #1;
      check("ready_c0", 32'(ready), 32'd0);
      c = 0;
      while (1) begin
         @(negedge clock);
         #1;
         c++;
         if (ready) break;
         if (c > 2 * N + 4) begin
            check("ready_timeout", 32'(ready), 32'd1);
            break;
         end
         check("addr", 32'(sram_addr), (c <= N) ? 32'(a_lo) : 32'(a_lo) + 1);
         if (is_wr) begin
            check("wr_we_n", 32'(sram_we_n), 32'd0);
            check("wr_dq_oe", 32'(sram_dq_oe), 32'd1);
            check("wr_oe_n", 32'(sram_oe_n), 32'd1);
            check("wr_dq", 32'(sram_dq_out), (c <= N) ? 32'(data[15:0]) : 32'(data[31:16]));
         end else begin
            check("rd_oe_n", 32'(sram_oe_n), 32'd0);
            check("rd_we_n", 32'(sram_we_n), 32'd1);
            check("rd_dq_oe", 32'(sram_dq_oe), 32'd0);
         end
      end
      check("stall_cycles", 32'(c), 32'(2 * N + 1));
      check("read_data", read_data, exp_rd);
      check_quiet("done");
      if (is_wr) ref_w[idx] = data;
      else exp_rdata = exp_rd;
      mem_w_en = 1'b0;
      mem_r_en = 1'b0;
   endtask

   initial begin
      for (int h = 0; h < DEPTH; h++) sram_mem[h] = pat(h);
      sram_mem[2] = 16'hBEEF;
      sram_mem[3] = 16'hDEAD;
      ref_w[1] = 32'hDEADBEEF;

      // Reset held, no request
      #12;
      check("rst_ready", 32'(ready), 32'd1);
      check_quiet("rst");
      check("rst_read_data", read_data, 32'd0);
      check("rst_addr", 32'(sram_addr), 32'd0);
      @(negedge clock);
      reset = 1'b1;

      txn(1'b1, 1'b0, 32'd1024, 32'h12345678);
      txn(1'b0, 1'b1, 32'd1028, 32'h0);
      check("rd_deadbeef", read_data, 32'hDEADBEEF);

      // Back-to-back write then read of the same word
      txn(1'b1, 1'b0, 32'd2048, 32'hCAFEF00D);
      txn(1'b0, 1'b1, 32'd2048, 32'h0);
      check("b2b_rd", read_data, 32'hCAFEF00D);

      // Reset during HIGH phase of a write
      @(negedge clock);
      mem_w_en = 1'b1;
      address  = 32'd8192;
      st_value = 32'hA5A55A5A;
      repeat (N + 1) @(negedge clock);
      #1;
      check("pre_rst_we_n", 32'(sram_we_n), 32'd0);
      reset = 1'b0;
      #1;
      check_quiet("midrst");
      check("midrst_addr", 32'(sram_addr), 32'd0);
      check("midrst_dq_out", 32'(sram_dq_out), 32'd0);
      check("midrst_read_data", read_data, 32'd0);
      check("midrst_ready_req", 32'(ready), 32'd0);
      mem_w_en = 1'b0;
      #1;
      check("midrst_ready", 32'(ready), 32'd1);
      exp_rdata = 32'd0;
      @(negedge clock);
      reset = 1'b1;
      txn(1'b0, 1'b1, 32'd1024, 32'h0);

      // Both enables: write wins, read_data untouched
      txn(1'b1, 1'b1, 32'd1032, 32'h0BADF00D);
      check("both_rd_kept", read_data, 32'h12345678);
      txn(1'b0, 1'b1, 32'd1032, 32'h0);

      // Idle: ready stays high, no strobes
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("idle_ready", 32'(ready), 32'd1);
         check_quiet("idle");
      end

      // Address wrap below DATA_BASE
      txn(1'b1, 1'b0, 32'd0, 32'h11223344);
      txn(1'b0, 1'b1, 32'd3, 32'h0);

      // Random traffic over a small window, ignored byte bits included
      for (int i = 0; i < 24; i++) begin
         logic [31:0] a;
         logic w;
         a = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         w = 1'($urandom_range(0, 1));
         txn(w, !w, a, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
